// File: rtl/arm_mc_controller_pkg.sv
// Shared definitions for the multicycle ARM controller: state codes, ALU
// operation codes, data-processing cmd values and condition-field codes.
package arm_mc_controller_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: return ALU_ADD;
            CMD_SUB: return ALU_SUB;
            CMD_AND: return ALU_AND;
            CMD_ORR: return ALU_ORR;
            CMD_CMP: return ALU_SUB;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/arm_mc_controller_condcheck.sv
// Evaluates an ARM condition field against the NZCV flags; NV (1111) never passes.
module arm_condcheck
    import arm_mc_controller_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] NZCV,
    output logic       CondEx
);

    logic n, z, c, v;
    assign {n, z, c, v} = NZCV;

    always_comb begin
        CondEx = 1'b0;
        case (cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM with condition gating, flag register and
// cycle / retired-instruction performance counters.
module arm_mc_controller
    import arm_mc_controller_pkg::*;
#(
    parameter int MEM_HS = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [19:0]      Instr,
    input  logic [3:0]       ALUFlags,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic [2:0]       ALUControl,
    output logic             busy,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    logic [3:0]       nzcv_q;
    logic             cond_pass_q;
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ex, mem_go, is_cmp, rd_pc, retire, nzcv_load;
    logic       unused_instr;

    assign cond         = Instr[19:16];
    assign op           = Instr[15:14];
    assign funct        = Instr[13:8];
    assign rd           = Instr[3:0];
    assign unused_instr = ^Instr[7:4];

    assign mem_go = (MEM_HS != 0) ? mem_ready : 1'b1;
    assign is_cmp = (funct[4:1] == CMD_CMP);
    assign rd_pc  = (rd == 4'd15);

    arm_condcheck u_condcheck (
        .cond   (cond),
        .NZCV   (nzcv_q),
        .CondEx (cond_ex)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (mem_go) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_go) state_d = S_MEMWB;
            S_MEMWR:  if (mem_go) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB,
            S_MEMWB,
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign retire    = busy && (state_q != S_FETCH) && (state_d == S_FETCH);
    assign nzcv_load = ((state_q == S_EXECR) || (state_q == S_EXECI)) && funct[0] && cond_pass_q;

    // The condition is frozen at DECODE so an S-suffixed instruction's own
    // flag update cannot change whether its ALUWB writeback happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            nzcv_q      <= 4'b0000;
            cond_pass_q <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) cond_pass_q <= cond_ex;
            if (nzcv_load)           nzcv_q      <= ALUFlags;
            if (busy)                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (retire)              instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = busy ? op : 2'b00;
        RegSrc     = busy ? {op == 2'b01, op == 2'b10} : 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_go;
                PCWrite   = mem_go;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_pass_q & mem_go;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_pass_q;
                PCWrite   = cond_pass_q & rd_pc;
            end
            S_EXECR: ALUControl = alu_decode(funct[4:1]);
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(funct[4:1]);
            end
            S_ALUWB: begin
                RegWrite = cond_pass_q & ~is_cmp;
                PCWrite  = cond_pass_q & ~is_cmp & rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_pass_q;
            end
            default: ;
        endcase
    end

    assign state_o   = state_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Self-checking bench for arm_mc_controller: directed scenarios plus a
// randomized instruction stream checked against a transaction-level model.
module tb_arm_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [19:0] Instr = 20'h0;
    logic [3:0]  ALUFlags = 4'h0;
    logic        mem_ready = 1'b1;
    logic        reset_nh = 1'b1;
    logic        start_nh = 1'b0;

    logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [2:0]  ALUControl;
    logic        busy;
    logic [3:0]  state_o;
    logic [31:0] cycle_cnt, instr_cnt;

    logic        nh_PCWrite, nh_IRWrite, nh_RegWrite, nh_busy;
    logic [3:0]  nh_state;
    logic [7:0]  nh_cycle_cnt, nh_instr_cnt;
    wire  [13:0] nh_unused;

    int errors = 0;
    int checks = 0;
    int path_q[$];

    always #5 clk = ~clk;

    arm_mc_controller #(.MEM_HS(1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Instr(Instr), .ALUFlags(ALUFlags),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .busy(busy), .state_o(state_o), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    arm_mc_controller #(.MEM_HS(0), .CNT_W(8)) dut_nh (
        .clk(clk), .reset(reset_nh), .start(start_nh), .Instr(Instr), .ALUFlags(ALUFlags),
        .mem_ready(1'b0), .PCWrite(nh_PCWrite), .AdrSrc(nh_unused[2]), .IRWrite(nh_IRWrite),
        .MemWrite(nh_unused[0]), .RegWrite(nh_RegWrite), .ALUSrcA(nh_unused[1]),
        .ALUSrcB(nh_unused[4:3]), .ResultSrc(nh_unused[6:5]), .ImmSrc(nh_unused[8:7]),
        .RegSrc(nh_unused[10:9]), .ALUControl(nh_unused[13:11]), .busy(nh_busy),
        .state_o(nh_state), .cycle_cnt(nh_cycle_cnt), .instr_cnt(nh_instr_cnt)
    );

    wire [16:0] act_ctrl = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA,
                            ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

    // ---------------- reference model ----------------
    function automatic bit cond_holds(logic [3:0] c, logic [3:0] f);
        bit n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic logic [2:0] alu_model(logic [3:0] cmd);
        case (cmd)
            4'd4:  return 3'd0;
            4'd2:  return 3'd1;
            4'd0:  return 3'd2;
            4'd12: return 3'd3;
            4'd10: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    function automatic void build_path(logic [19:0] ins);
        path_q.delete();
        path_q.push_back(1);
        path_q.push_back(2);
        case (ins[15:14])
            2'b00: begin path_q.push_back(ins[13] ? 8 : 7); path_q.push_back(9); end
            2'b01: begin
                path_q.push_back(3);
                if (ins[8]) begin path_q.push_back(4); path_q.push_back(5); end
                else path_q.push_back(6);
            end
            2'b10: path_q.push_back(10);
            default: ;
        endcase
    endfunction

    function automatic logic [16:0] exp_ctrl(int s, logic [19:0] ins, bit ok, bit mr);
        logic [1:0] op, asb, res, imm, rs;
        logic [3:0] cmd;
        logic [2:0] alu;
        logic pcw, adr, irw, mw, rw, asa;
        bit cmp, rd15;
        op = ins[15:14];
        cmd = ins[12:9];
        cmp = (cmd == 4'b1010);
        rd15 = (ins[3:0] == 4'hF);
        {pcw, adr, irw, mw, rw, asa} = '0;
        asb = 2'd0; res = 2'd0; imm = 2'd0; rs = 2'd0; alu = 3'd0;
        if (s != 0) begin
            imm = op;
            rs = {op == 2'b01, op == 2'b10};
        end
        case (s)
            1: begin asa = 1'b1; asb = 2'd2; res = 2'd2; irw = mr; pcw = mr; end
            2: begin asa = 1'b1; asb = 2'd2; res = 2'd2; end
            3: asb = 2'd1;
            4: adr = 1'b1;
            5: begin res = 2'd1; rw = ok; pcw = ok && rd15; end
            6: begin adr = 1'b1; mw = ok && mr; end
            7: alu = alu_model(cmd);
            8: begin asb = 2'd1; alu = alu_model(cmd); end
            9: begin rw = ok && !cmp; pcw = ok && !cmp && rd15; end
            10: begin asb = 2'd1; res = 2'd2; pcw = ok; end
            default: ;
        endcase
        return {pcw, adr, irw, mw, rw, asa, asb, res, imm, rs, alu};
    endfunction

    function automatic logic [19:0] rand_instr();
        int unsigned kind;
        logic [3:0] cond, cmd, rd, rn;
        logic [5:0] funct;
        logic [1:0] op;
        kind = $urandom_range(0, 5);
        cond = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15));
        rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        rn = 4'($urandom);
        funct = 6'($urandom);
        case ($urandom_range(0, 5))
            0: cmd = 4'd0;
            1: cmd = 4'd2;
            2: cmd = 4'd4;
            3: cmd = 4'd10;
            4: cmd = 4'd12;
            default: cmd = 4'($urandom);
        endcase
        case (kind)
            0, 1: begin op = 2'b00; funct[5] = (kind == 1); funct[4:1] = cmd; end
            2: begin op = 2'b01; funct[0] = 1'b1; end
            3: begin op = 2'b01; funct[0] = 1'b0; end
            4: op = 2'b10;
            default: op = 2'b11;
        endcase
        return {cond, op, funct, rn, rd};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic steps(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic restart();
        reset = 1'b1; start = 1'b0; mem_ready = 1'b1;
        steps(1);
        reset = 1'b0; start = 1'b1;
        steps(1);
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Instr = 20'hE0811; mem_ready = 1'b1; reset = 1'b1;
        steps(1);
        @(negedge clk);
        checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (act_ctrl !== 17'h0) begin errors++; $display("FAIL reset_ctrl got %05h want 00000", act_ctrl); end
        checks++; if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cycle_cnt, instr_cnt); end
        @(posedge clk); #1;
        reset = 1'b0;
        steps(3);
        @(negedge clk);
        checks++; if (state_o !== 4'd0 || cycle_cnt !== 32'd0) begin
            errors++; $display("FAIL idle_hold got state=%0d cyc=%0d want 0/0", state_o, cycle_cnt); end
        $display("reset: idle state and zero outputs examined");
    endtask

    task automatic test_add();
        int exp_s[5] = '{1, 2, 7, 9, 1};
        restart();
        Instr = 20'hE0811;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (state_o !== 4'(exp_s[i])) begin
                errors++; $display("FAIL add_state[%0d] got %0d want %0d", i, state_o, exp_s[i]); end
            if (i == 2) begin
                checks++; if (ALUControl !== 3'd0 || ALUSrcB !== 2'd0) begin
                    errors++; $display("FAIL add_exec got alu=%0d srcb=%0d want 0/0", ALUControl, ALUSrcB); end
            end
            if (i == 3) begin
                checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL add_regwrite got %0b want 1", RegWrite); end
            end
            if (i == 4) begin
                checks++; if (instr_cnt !== 32'd1 || cycle_cnt !== 32'd4) begin
                    errors++; $display("FAIL add_cnt got %0d/%0d want 1/4", instr_cnt, cycle_cnt); end
            end
            @(posedge clk); #1;
        end
        $display("add: ADD R1 sequence examined");
    endtask

    task automatic test_ldr_stall();
        logic [31:0] c0 = 32'd0;
        restart();
        Instr = {4'hE, 2'b01, 6'b011001, 4'h0, 4'h2};
        steps(3);
        for (int j = 0; j < 4; j++) begin
            mem_ready = (j == 3);
            @(negedge clk);
            checks++; if (state_o !== 4'd4) begin errors++; $display("FAIL ldr_hold[%0d] got %0d want 4", j, state_o); end
            if (j == 0) c0 = cycle_cnt;
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (state_o !== 4'd5 || RegWrite !== 1'b1) begin
            errors++; $display("FAIL ldr_wb got state=%0d rw=%0b want 5/1", state_o, RegWrite); end
        checks++; if (cycle_cnt !== c0 + 32'd4) begin
            errors++; $display("FAIL ldr_cycles got %0d want %0d", cycle_cnt, c0 + 32'd4); end
        @(posedge clk); #1;
        $display("ldr: MEMRD stall of 3 cycles examined");
    endtask

    task automatic test_branch_cond();
        for (int bne = 0; bne < 2; bne++) begin
            restart();
            ALUFlags = 4'b0100;
            Instr = {4'hE, 2'b00, 6'b000101, 4'h1, 4'h2};
            steps(4);
            ALUFlags = 4'b0000;
            Instr = {(bne == 1) ? 4'h1 : 4'h0, 2'b10, 6'b101000, 8'h00};
            steps(2);
            @(negedge clk);
            checks++; if (state_o !== 4'd10 || PCWrite !== (bne == 0)) begin
                errors++; $display("FAIL branch_pcw[%0d] got state=%0d pcw=%0b want 10/%0b", bne, state_o, PCWrite, bne == 0); end
            checks++; if (ALUSrcB !== 2'd1 || ResultSrc !== 2'd2 || ImmSrc !== 2'd2 || RegSrc !== 2'b01) begin
                errors++; $display("FAIL branch_ctrl got %05h", act_ctrl); end
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (state_o !== 4'd1 || instr_cnt !== 32'd2) begin
                errors++; $display("FAIL branch_ret got state=%0d ic=%0d want 1/2", state_o, instr_cnt); end
            @(posedge clk); #1;
            $display("branch: SUBS then %s examined", (bne == 1) ? "BNE" : "BEQ");
        end
    endtask

    task automatic test_str_cond();
        for (int al = 0; al < 2; al++) begin
            restart();
            Instr = {(al == 1) ? 4'hE : 4'hF, 2'b01, 6'b011000, 4'h0, 4'h3};
            steps(3);
            for (int j = 0; j < 3; j++) begin
                mem_ready = (j == 2);
                @(negedge clk);
                checks++; if (state_o !== 4'd6 || AdrSrc !== 1'b1) begin
                    errors++; $display("FAIL str_state[%0d] got %0d/%0b want 6/1", j, state_o, AdrSrc); end
                checks++; if (MemWrite !== (al == 1 && j == 2)) begin
                    errors++; $display("FAIL str_memwrite[%0d,%0d] got %0b want %0b", al, j, MemWrite, al == 1 && j == 2); end
                @(posedge clk); #1;
            end
            @(negedge clk);
            checks++; if (state_o !== 4'd1) begin errors++; $display("FAIL str_done got %0d want 1", state_o); end
            @(posedge clk); #1;
            $display("str: cond=%s write gating examined", (al == 1) ? "AL" : "NV");
        end
    endtask

    task automatic test_reset_in_memwr();
        restart();
        Instr = {4'hE, 2'b01, 6'b011000, 4'h0, 4'h3};
        steps(3);
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        checks++; if (state_o !== 4'd6) begin errors++; $display("FAIL rstwr_pre got %0d want 6", state_o); end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (state_o !== 4'd0 || busy !== 1'b0 || MemWrite !== 1'b0) begin
            errors++; $display("FAIL rstwr_state got %0d/%0b/%0b want 0/0/0", state_o, busy, MemWrite); end
        checks++; if (act_ctrl !== 17'h0 || cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            errors++; $display("FAIL rstwr_clear got ctrl=%05h cyc=%0d ic=%0d want 0", act_ctrl, cycle_cnt, instr_cnt); end
        @(posedge clk); #1;
        $display("reset: mid-MEMWR reset examined");
    endtask

    task automatic test_no_handshake();
        int exp_s[6] = '{1, 2, 3, 4, 5, 1};
        reset_nh = 1'b1;
        steps(1);
        reset_nh = 1'b0; start_nh = 1'b1;
        Instr = {4'hE, 2'b01, 6'b011001, 4'h0, 4'h4};
        steps(1);
        start_nh = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (nh_state !== 4'(exp_s[i]) || nh_busy !== 1'b1) begin
                errors++; $display("FAIL nh_state[%0d] got %0d want %0d", i, nh_state, exp_s[i]); end
            if (i == 0) begin
                checks++; if (nh_IRWrite !== 1'b1 || nh_PCWrite !== 1'b1) begin
                    errors++; $display("FAIL nh_fetch got ir=%0b pc=%0b want 1/1", nh_IRWrite, nh_PCWrite); end
            end
            if (i == 4) begin
                checks++; if (nh_RegWrite !== 1'b1) begin errors++; $display("FAIL nh_wb got %0b want 1", nh_RegWrite); end
            end
            if (i == 5) begin
                checks++; if (nh_instr_cnt !== 8'd1 || nh_cycle_cnt !== 8'd5) begin
                    errors++; $display("FAIL nh_cnt got %0d/%0d want 1/5", nh_instr_cnt, nh_cycle_cnt); end
            end
            @(posedge clk); #1;
        end
        reset_nh = 1'b1;
        $display("no-handshake: LDR in 5 states examined");
    endtask

    task automatic test_random();
        logic [19:0] ins;
        logic [3:0]  fl;
        logic [3:0]  flags_m = 4'h0;
        logic [16:0] e;
        bit ok, mr, mem_state;
        int s, k, cyc_m = 0, ins_m = 0;
        restart();
        for (int n = 0; n < 60; n++) begin
            ins = rand_instr();
            build_path(ins);
            ok = cond_holds(ins[19:16], flags_m);
            foreach (path_q[i]) begin
                s = path_q[i];
                mem_state = (s == 1 || s == 4 || s == 6);
                k = mem_state ? int'($urandom_range(0, 2)) : 0;
                for (int j = 0; j <= k; j++) begin
                    mr = mem_state ? (j == k) : 1'($urandom_range(0, 1));
                    fl = 4'($urandom);
                    Instr = ins; mem_ready = mr; ALUFlags = fl; start = 1'($urandom);
                    @(negedge clk);
                    e = exp_ctrl(s, ins, ok, mr);
                    checks++; if (state_o !== 4'(s) || busy !== 1'b1) begin
                        errors++; $display("FAIL rnd_state n=%0d got %0d want %0d", n, state_o, s); end
                    checks++; if (act_ctrl !== e) begin
                        errors++; $display("FAIL rnd_ctrl n=%0d s=%0d ins=%05h got %05h want %05h", n, s, ins, act_ctrl, e); end
                    checks++; if (cycle_cnt !== 32'(cyc_m) || instr_cnt !== 32'(ins_m)) begin
                        errors++; $display("FAIL rnd_cnt n=%0d got %0d/%0d want %0d/%0d", n, cycle_cnt, instr_cnt, cyc_m, ins_m); end
                    @(posedge clk); #1;
                    cyc_m++;
                    if ((s == 7 || s == 8) && ins[8] && ok) flags_m = fl;
                end
            end
            ins_m++;
            $display("txn %0d instr=%05h cond_ok=%0b states=%0d cycles=%0d", n, ins, ok, path_q.size(), cyc_m);
        end
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_ldr_stall();
        test_branch_cond();
        test_str_cond();
        test_reset_in_memwr();
        test_no_handshake();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm_mc_controller.md
ARM_MC_CONTROLLER -- requirements
Module: arm_mc_controller

Interface
REQ-001 SHALL have parameter MEM_HS, default 1, meaning 1 = FETCH/MEMRD/MEMWR wait for mem_ready, 0 = mem_ready ignored.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the cycle and retired-instruction counters.
REQ-003 SHALL use one clock, clk, with synchronous active-high reset, reset; clk and reset are listed first.
REQ-004 Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- start  in  1  run request
- Instr  in  20  instruction bits [31:12]
- ALUFlags  in  4  NZCV from ALU
- mem_ready  in  1  memory access complete
REQ-005 Ports:
- PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA  out  1  datapath controls
- ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2  datapath controls
- ALUControl  out  3  ALU operation
- busy  out  1  controller running
- state_o  out  4  current state code
- cycle_cnt, instr_cnt  out  CNT_W  performance counters

Function
REQ-006 SHALL implement states IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXECR=7, EXECI=8, ALUWB=9, BRANCH=10; state_o carries this code.
REQ-007 IDLE->FETCH when start=1; start is ignored in every other state.
REQ-008 FETCH SHALL hold until mem_ready=1 (when MEM_HS=1), then go to DECODE; IRWrite=1 and PCWrite=1 only in the cycle that leaves FETCH.
REQ-009 DECODE transitions: op=01 -> MEMADR; op=10 -> BRANCH; op=00 with funct[5]=0 -> EXECR; op=00 with funct[5]=1 -> EXECI; op=11 -> FETCH, counted as retired.
REQ-010 MEMADR -> MEMRD if L (funct[0]) = 1, else -> MEMWR. MEMRD holds until mem_ready, then -> MEMWB. MEMWR holds until mem_ready, then -> FETCH.
REQ-011 EXECR/EXECI -> ALUWB; ALUWB, MEMWB and BRANCH -> FETCH.
REQ-012 Output encodings per state:
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD
- MEMRD/MEMWR: AdrSrc=1
- MEMWB: ResultSrc=01
- EXECR: ALUSrcB=00
- EXECI: ALUSrcB=01
- ALUWB: ResultSrc=00
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ADD
- unlisted outputs are 0
REQ-013 ALUControl in EXECR/EXECI: cmd ADD(0100)=000, SUB(0010)=001, AND(0000)=010, ORR(1100)=011, CMP(1010)=001; any other cmd=000.
REQ-014 ImmSrc=op and RegSrc={op==01, op==10} in all states.
REQ-015 CondEx SHALL evaluate Instr[31:28] (EQ..LE, AL=1110; 1111 is false) against the internal NZCV register.
REQ-016 Gating by CondEx:
- RegWrite in MEMWB/ALUWB only if CondEx, and never for CMP.
- MemWrite in MEMWR only if CondEx and mem_ready.
- PCWrite on branch (BRANCH) or Rd=15 writeback only if CondEx.
REQ-017 NZCV register SHALL load ALUFlags at the end of EXECR/EXECI when S=1 and CondEx; NZCV is unchanged otherwise.
REQ-018 cycle_cnt SHALL increment each cycle busy=1; instr_cnt SHALL increment on each transition into FETCH from a non-IDLE state; both wrap modulo 2^CNT_W.
REQ-019 busy=1 in every state except IDLE; once started, the controller never returns to IDLE except by reset.

Reset
REQ-020 reset=1 SHALL force IDLE, NZCV=0000, both counters=0, and all control outputs 0 on the next edge, including mid-instruction; a pending memory write is abandoned.

Structure
REQ-021 A shared package SHALL hold the state enum, ALUControl codes, condition-code constants and cmd constants.
REQ-022 The condition check SHALL be a sub-module, arm_condcheck (cond, NZCV -> CondEx).

Verification
REQ-023 Reset then start=1: ADD R1 (E0811002) with mem_ready=1 -> states 1,2,7,9,1; RegWrite=1 in ALUWB; instr_cnt=1.
REQ-024 LDR with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles; cycle_cnt grows by 4 over that period.
REQ-025 SUBS producing Z=1, followed by BEQ -> PCWrite=1 in BRANCH; the same sequence with BNE -> PCWrite=0.
REQ-026 STR with cond=1111 -> MemWrite stays 0 through MEMWR.
REQ-027 Reset asserted in MEMWR -> next cycle state_o=0, MemWrite=0, counters 0.
REQ-028 MEM_HS=0 with mem_ready tied 0 -> LDR completes in 5 states.
